act_fetch_sched: RTL and testbench

ACT_FETCH_SCHED -- requirements
Module: act_fetch_sched

---
 rtl/act_fetch_sched_pkg.sv | 16 +
 rtl/act_fetch_sched_sat_counter.sv | 30 +++
 rtl/act_fetch_sched.sv | 148 ++++++++++++++
 tb/tb_act_fetch_sched.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_fetch_sched_pkg.sv
// Shared accelerator package for the activation fetch scheduler.
// Holds the default block-count and stall-counter widths and the FSM encodings.
package act_fetch_sched_pkg;

   localparam int BLK_W_DEFAULT   = 16;
   localparam int STALL_W_DEFAULT = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      WAITRDY = 3'd2,
      OFFER   = 3'd3,
      FIN     = 3'd4
   } fetchState_e;

endpackage

// File: rtl/act_fetch_sched_sat_counter.sv
// Saturating up-counter used for the stall statistic.
// Synchronous clear wins over increment; the count sticks at all-ones.
module sat_counter
   import act_fetch_sched_pkg::*;
#(
   parameter int W = STALL_W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;

   // Count up on each increment request, holding once every bit is set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_q <= cnt_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/act_fetch_sched.sv
// Activation fetch scheduler: walks a layer block by block, asking the
// distributor for each block and offering it to the PE array.
// Optional build macro ACT_SCHED_PREFETCH_EN: a non-final transfer raises the
// next fetch pulse in the transfer cycle itself and skips the FETCH state.
module act_fetch_sched
   import act_fetch_sched_pkg::*;
#(
   parameter int BLK_W   = BLK_W_DEFAULT,
   parameter int STALL_W = STALL_W_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               Start_i,
   input  logic               Abort_i,
   input  logic [BLK_W-1:0]   CfgNumBlk_i,
   output logic               PlsFetch_o,
   input  logic               RdyAct_i,
   output logic               ActVal_o,
   input  logic               PeRdy_i,
   output logic [BLK_W-1:0]   BlkIdx_o,
   output logic               Busy_o,
   output logic               Done_o,
   output logic [STALL_W-1:0] StallCnt_o,
   output logic               ErrStart_o
);

   fetchState_e      state_q;
   logic             plsFetch_q;
   logic             actVal_q;
   logic             done_q;
   logic             busy_q;
   logic             errStart_q;
   logic [BLK_W-1:0] blkIdx_q;
   logic [BLK_W-1:0] numBlk_q;

   logic [BLK_W-1:0] nextIdx;
   logic             transfer;
   logic             lastBlk;
   logic             stallClr;
   logic             stallInc;

   assign transfer = actVal_q & PeRdy_i;
   assign nextIdx  = blkIdx_q + {{(BLK_W-1){1'b0}}, 1'b1};
   assign lastBlk  = (nextIdx == numBlk_q);
   assign stallClr = Start_i & (state_q == IDLE) & (CfgNumBlk_i != '0);
   assign stallInc = actVal_q & ~PeRdy_i;

   // Layer sequencer; every output is registered and set on entry to the
   // state that owns it, and Abort beats any transfer in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         plsFetch_q <= 1'b0;
         actVal_q   <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         errStart_q <= 1'b0;
         blkIdx_q   <= '0;
         numBlk_q   <= '0;
      end else begin
         plsFetch_q <= 1'b0;
         done_q     <= 1'b0;
         if (Start_i && (state_q != IDLE)) begin
            errStart_q <= 1'b1;
         end
         if (Abort_i && (state_q != IDLE)) begin
            state_q  <= IDLE;
            actVal_q <= 1'b0;
            busy_q   <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (Start_i) begin
                     errStart_q <= 1'b0;
                     busy_q     <= 1'b1;
                     if (CfgNumBlk_i != '0) begin
                        numBlk_q   <= CfgNumBlk_i;
                        blkIdx_q   <= '0;
                        plsFetch_q <= 1'b1;
                        state_q    <= FETCH;
                     end else begin
                        done_q  <= 1'b1;
                        state_q <= FIN;
                     end
                  end
               end
               FETCH: begin
                  state_q <= WAITRDY;
               end
               WAITRDY: begin
                  if (RdyAct_i) begin
                     actVal_q <= 1'b1;
                     state_q  <= OFFER;
                  end
               end
               OFFER: begin
                  if (transfer) begin
                     actVal_q <= 1'b0;
                     if (lastBlk) begin
                        done_q  <= 1'b1;
                        state_q <= FIN;
                     end else begin
                        blkIdx_q <= nextIdx;
`ifdef ACT_SCHED_PREFETCH_EN
                        state_q  <= WAITRDY;
`else
                        plsFetch_q <= 1'b1;
                        state_q    <= FETCH;
`endif
                     end
                  end
               end
               FIN: begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
               default: begin
                  actVal_q <= 1'b0;
                  busy_q   <= 1'b0;
                  state_q  <= IDLE;
               end
            endcase
         end
      end
   end

   sat_counter #(
      .W(STALL_W)
   ) uStallCnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (stallClr),
      .inc_i (stallInc),
      .cnt_o (StallCnt_o)
   );

`ifdef ACT_SCHED_PREFETCH_EN
   assign PlsFetch_o = plsFetch_q | (transfer & ~lastBlk & ~Abort_i);
`else
   assign PlsFetch_o = plsFetch_q;
`endif
   assign ActVal_o   = actVal_q;
   assign BlkIdx_o   = blkIdx_q;
   assign Busy_o     = busy_q;
   assign Done_o     = done_q;
   assign ErrStart_o = errStart_q;

endmodule

// File: tb/tb_act_fetch_sched.sv
// Bench for act_fetch_sched: directed layers with a scoreboard of expected
// fetch / transfer / done events, plus direct checks of status outputs.
module tb_act_fetch_sched;

`ifdef ACT_SCHED_PREFETCH_EN
   localparam int PF = 1;
`else
   localparam int PF = 0;
`endif

   typedef enum int {EV_FETCH = 0, EV_XFER = 1, EV_DONE = 2} evKind_e;
   typedef struct {
      evKind_e     kind;
      logic [15:0] idx;
   } sbEv_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        Start;
   logic        Abort;
   logic [15:0] CfgNumBlk;
   logic        PlsFetch;
   logic        RdyAct;
   logic        ActVal;
   logic        PeRdy;
   logic [15:0] BlkIdx;
   logic        Busy;
   logic        Done;
   logic [15:0] StallCnt;
   logic        ErrStart;

   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    startCyc = 0;
   int    rdyCnt = 0;
   sbEv_t expQ[$];
   int    xferCycles[$];
   int    fetchCycles[$];

   act_fetch_sched #(
      .BLK_W   (16),
      .STALL_W (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .Start_i     (Start),
      .Abort_i     (Abort),
      .CfgNumBlk_i (CfgNumBlk),
      .PlsFetch_o  (PlsFetch),
      .RdyAct_i    (RdyAct),
      .ActVal_o    (ActVal),
      .PeRdy_i     (PeRdy),
      .BlkIdx_o    (BlkIdx),
      .Busy_o      (Busy),
      .Done_o      (Done),
      .StallCnt_o  (StallCnt),
      .ErrStart_o  (ErrStart)
   );

   // Free-running clock and a cycle counter for latency measurements.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic pushExp(input evKind_e kind, input int idx);
      sbEv_t e;
      e.kind = kind;
      e.idx  = 16'(idx);
      expQ.push_back(e);
   endtask

   task automatic scoreEvent(input evKind_e kind, input logic [15:0] idx);
      sbEv_t e;
      checks++;
      if (expQ.size() == 0) begin
         errors++;
         $display("[TB] FAIL sb_event: got kind %0d idx %0d, expected no event", int'(kind), idx);
      end else begin
         e = expQ.pop_front();
         if ((e.kind != kind) || (e.idx !== idx)) begin
            errors++;
            $display("[TB] FAIL sb_event: got kind %0d idx %0d, expected kind %0d idx %0d",
                     int'(kind), idx, int'(e.kind), e.idx);
         end
      end
   endtask

   // Pulse Start for one cycle with the given block count.
   task automatic applyStimulus(input int numBlk);
      @(negedge clk);
      Start     = 1'b1;
      CfgNumBlk = 16'(numBlk);
      startCyc  = cyc;
      @(negedge clk);
      Start     = 1'b0;
   endtask

   task automatic waitIdle(input string name, input int budget);
      int n = 0;
      while ((Busy || (expQ.size() != 0)) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, 32'(n < budget), 32'd1);
   endtask

   task automatic waitActVal(input string name, input int idx, input int budget);
      int n = 0;
      while (!(ActVal && (BlkIdx == 16'(idx))) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, 32'(n < budget), 32'd1);
   endtask

   // Distributor model: raise RdyAct two cycles after each fetch pulse and
   // drop it once the block is on offer.
   initial begin
      RdyAct = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n || !Busy) begin
            RdyAct = 1'b0;
            rdyCnt = 0;
         end else begin
            if (ActVal) RdyAct = 1'b0;
            if (rdyCnt > 0) begin
               rdyCnt--;
               if (rdyCnt == 0) RdyAct = 1'b1;
            end
            if (PlsFetch) rdyCnt = 2;
         end
      end
   end

   // Monitor: every observed fetch, transfer and done is matched in order
   // against the expected-event queue.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rst_n) begin
            if (ActVal && PeRdy) begin
               xferCycles.push_back(cyc);
               scoreEvent(EV_XFER, BlkIdx);
            end
            if (PlsFetch) begin
               fetchCycles.push_back(cyc);
               scoreEvent(EV_FETCH, BlkIdx);
            end
            if (Done) scoreEvent(EV_DONE, 16'd0);
         end
      end
   end

   // Watchdog so a stuck design still ends the run.
   initial begin
      #1500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      int d;
      rst_n     = 1'b0;
      Start     = 1'b0;
      Abort     = 1'b0;
      CfgNumBlk = 16'd0;
      PeRdy     = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rst_plsfetch", 32'(PlsFetch), 32'd0);
      checkOutput("rst_actval",   32'(ActVal),   32'd0);
      checkOutput("rst_done",     32'(Done),     32'd0);
      checkOutput("rst_busy",     32'(Busy),     32'd0);
      checkOutput("rst_errstart", 32'(ErrStart), 32'd0);
      checkOutput("rst_blkidx",   32'(BlkIdx),   32'd0);
      checkOutput("rst_stallcnt", 32'(StallCnt), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] three-block layer");
      for (int i = 0; i < 3; i++) begin
         pushExp(EV_FETCH, (i == 0) ? 0 : i - PF);
         pushExp(EV_XFER, i);
      end
      pushExp(EV_DONE, 0);
      applyStimulus(3);
      checkOutput("l3_busy", 32'(Busy), 32'd1);
      waitIdle("l3_idle", 200);
      checkOutput("l3_stallcnt", 32'(StallCnt), 32'd0);

      $display("[TB] empty layer");
      pushExp(EV_DONE, 0);
      applyStimulus(0);
      checkOutput("l0_done",     32'(Done),     32'd1);
      checkOutput("l0_busy",     32'(Busy),     32'd1);
      checkOutput("l0_plsfetch", 32'(PlsFetch), 32'd0);
      checkOutput("l0_actval",   32'(ActVal),   32'd0);
      @(negedge clk);
      checkOutput("l0_done_end", 32'(Done), 32'd0);
      checkOutput("l0_busy_end", 32'(Busy), 32'd0);

      $display("[TB] start while busy");
      pushExp(EV_FETCH, 0);
      pushExp(EV_XFER, 0);
      pushExp(EV_FETCH, 1 - PF);
      pushExp(EV_XFER, 1);
      pushExp(EV_DONE, 0);
      applyStimulus(2);
      @(negedge clk);
      applyStimulus(5);
      checkOutput("err_set", 32'(ErrStart), 32'd1);
      waitIdle("err_idle", 200);
      checkOutput("err_sticky", 32'(ErrStart), 32'd1);
      pushExp(EV_FETCH, 0);
      pushExp(EV_XFER, 0);
      pushExp(EV_DONE, 0);
      applyStimulus(1);
      checkOutput("err_clear", 32'(ErrStart), 32'd0);
      waitIdle("err2_idle", 200);

      $display("[TB] fetch timing after transfer");
      xferCycles.delete();
      fetchCycles.delete();
      pushExp(EV_FETCH, 0);
      pushExp(EV_XFER, 0);
      pushExp(EV_FETCH, 1 - PF);
      pushExp(EV_XFER, 1);
      pushExp(EV_DONE, 0);
      applyStimulus(2);
      waitIdle("pf_idle", 200);
      d = (fetchCycles.size() >= 1) ? fetchCycles[0] - startCyc : -99;
      checkOutput("start_to_fetch", 32'(d), 32'd1);
      d = ((fetchCycles.size() == 2) && (xferCycles.size() == 2)) ? fetchCycles[1] - xferCycles[0] : -99;
      checkOutput("xfer_to_fetch", 32'(d), 32'(1 - PF));

      $display("[TB] abort on transfer of block 1 of 4");
      PeRdy = 1'b0;
      pushExp(EV_FETCH, 0);
      pushExp(EV_XFER, 0);
      pushExp(EV_FETCH, 1 - PF);
      pushExp(EV_XFER, 1);
      applyStimulus(4);
      waitActVal("ab_blk0", 0, 100);
      PeRdy = 1'b1;
      @(negedge clk);
      PeRdy = 1'b0;
      waitActVal("ab_blk1", 1, 100);
      PeRdy = 1'b1;
      Abort = 1'b1;
      @(negedge clk);
      PeRdy = 1'b0;
      Abort = 1'b0;
      checkOutput("ab_busy",     32'(Busy),     32'd0);
      checkOutput("ab_actval",   32'(ActVal),   32'd0);
      checkOutput("ab_done",     32'(Done),     32'd0);
      checkOutput("ab_plsfetch", 32'(PlsFetch), 32'd0);
      repeat (10) @(negedge clk);
      checkOutput("ab_queue", 32'(expQ.size()), 32'd0);

      $display("[TB] reset mid-layer");
      PeRdy = 1'b1;
      pushExp(EV_FETCH, 0);
      applyStimulus(4);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("mr_busy",   32'(Busy),   32'd0);
      checkOutput("mr_blkidx", 32'(BlkIdx), 32'd0);
      checkOutput("mr_actval", 32'(ActVal), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      checkOutput("mr_queue", 32'(expQ.size()), 32'd0);
      checkOutput("mr_busy2", 32'(Busy), 32'd0);

      $display("[TB] long stall saturation");
      PeRdy = 1'b0;
      pushExp(EV_FETCH, 0);
      applyStimulus(1);
      waitActVal("st_offer", 0, 100);
      repeat (5) @(negedge clk);
      checkOutput("st_cnt5", 32'(StallCnt), 32'd5);
      repeat (70000) @(negedge clk);
      checkOutput("st_sat", 32'(StallCnt), 32'hFFFF);
      checkOutput("st_actval", 32'(ActVal), 32'd1);
      pushExp(EV_XFER, 0);
      pushExp(EV_DONE, 0);
      PeRdy = 1'b1;
      waitIdle("st_idle", 200);
      checkOutput("st_hold", 32'(StallCnt), 32'hFFFF);

      repeat (3) @(negedge clk);
      checkOutput("final_queue", 32'(expQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
